// File: rtl/spdif_frame_scheduler.sv
// ---------------------------------------------------------------------------
// spdif_frame_scheduler
//
// Purpose:
//   Pulls 24-bit audio samples from a byte FIFO (3 bytes per sample,
//   little-endian) and hands one 20-bit sample (s[23:4]) to the frame
//   assembler per subframe request. Samples alternate L/R starting with L
//   after reset. Each request also selects the preamble (B/M/W), the
//   channel-status bit and the frame index within the status block. A
//   request that finds no complete sample produces a silent, invalid
//   subframe. While play is high, such a subframe is also counted as an
//   underrun.
//
// Parameters:
//   BLOCK_FRAMES  frames per channel-status block (2..256)
//   CHSTAT_WORD   channel-status bits 0..31, LSB first
//
// Optional feature:
//   `define SPDIF_CHSTAT_EN  drives cs_bit from CHSTAT_WORD (frames 0..31).
//   When the macro is undefined, cs_bit is tied to 0.
//
// Ports:
//   clk           in   subframe-domain clock
//   rst_n         in   asynchronous active-low reset
//   play          in   1 = consume samples from the FIFO
//   fifo_empty    in   byte FIFO empty flag
//   fifo_dout     in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en    out  one-cycle FIFO pop strobe
//   frame_ready   in   one-cycle request for the next subframe
//   din           out  20-bit subframe sample
//   vin           out  validity (1 = din is real audio)
//   pre_sel       out  preamble: 00 = B, 01 = M, 10 = W
//   cs_bit        out  channel-status bit of the current subframe
//   frame_idx     out  frame number within the block
//   underrun_cnt  out  saturating count of underrun subframes
// ---------------------------------------------------------------------------
module spdif_frame_scheduler #(
    parameter int          BLOCK_FRAMES = 192,
    parameter logic [31:0] CHSTAT_WORD  = 32'h0200_0004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        play,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_dout,
    output logic        fifo_rd_en,
    input  logic        frame_ready,
    output logic [19:0] din,
    output logic        vin,
    output logic [1:0]  pre_sel,
    output logic        cs_bit,
    output logic [7:0]  frame_idx,
    output logic [7:0]  underrun_cnt
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_STAGED  = 2'd3;

    localparam logic [1:0] PRE_B = 2'b00;
    localparam logic [1:0] PRE_M = 2'b01;
    localparam logic [1:0] PRE_W = 2'b10;

    localparam logic [7:0] LAST_FRAME = 8'(BLOCK_FRAMES - 1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [7:0] wrap_frame(input logic [7:0] v);
        return (v == LAST_FRAME) ? 8'd0 : v + 8'd1;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] sample_q, sample_d;
    logic        chan_q, chan_d;          // 0 = next subframe is left
    logic [7:0]  next_frame_q, next_frame_d;
    logic [19:0] din_q, din_d;
    logic        vin_q, vin_d;
    logic [1:0]  pre_q, pre_d;
    logic [7:0]  frame_idx_q, frame_idx_d;
    logic [7:0]  und_q, und_d;

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        sample_d     = sample_q;
        chan_d       = chan_q;
        next_frame_d = next_frame_q;
        din_d        = din_q;
        vin_d        = vin_q;
        pre_d        = pre_q;
        frame_idx_d  = frame_idx_q;
        und_d        = und_q;
        fifo_rd_en   = 1'b0;

        // Fetch side: one byte every two cycles (pop, then capture).
        case (state_q)
            ST_IDLE: begin
                if (play) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // A pending capture always sits in CAPTURE, so being in
                // FETCH already means no pop is outstanding.
                if (play && !fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_d    = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                case (byte_cnt_q)
                    2'd0:    sample_d[7:0]   = fifo_dout;
                    2'd1:    sample_d[15:8]  = fifo_dout;
                    default: sample_d[23:16] = fifo_dout;
                endcase
                if (byte_cnt_q == 2'd2) begin
                    byte_cnt_d = 2'd0;
                    state_d    = ST_STAGED;
                end else begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    state_d    = ST_FETCH;
                end
            end
            default: begin
                if (frame_ready) state_d = ST_FETCH;
            end
        endcase

        // Subframe side: every request consumes one L/R slot, even when it
        // has to emit silence, so channel order never slips.
        if (frame_ready) begin
            if (state_q == ST_STAGED) begin
                din_d = sample_q[23:4];
                vin_d = 1'b1;
            end else begin
                din_d = 20'd0;
                vin_d = 1'b0;
                if (play) und_d = sat_inc8(und_q);
            end
            chan_d = ~chan_q;
            if (!chan_q) begin
                frame_idx_d = next_frame_q;
                pre_d       = (next_frame_q == 8'd0) ? PRE_B : PRE_M;
            end else begin
                pre_d        = PRE_W;
                next_frame_d = wrap_frame(next_frame_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= 2'd0;
            chan_q       <= 1'b0;
            next_frame_q <= 8'd0;
            din_q        <= 20'd0;
            vin_q        <= 1'b0;
            pre_q        <= PRE_B;
            frame_idx_q  <= 8'd0;
            und_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            chan_q       <= chan_d;
            next_frame_q <= next_frame_d;
            din_q        <= din_d;
            vin_q        <= vin_d;
            pre_q        <= pre_d;
            frame_idx_q  <= frame_idx_d;
            und_q        <= und_d;
        end
    end

    // Sample assembly register: reset of state and byte counter is enough
    // to discard a partial or staged sample.
    always_ff @(posedge clk) begin
        sample_q <= sample_d;
    end

`ifdef SPDIF_CHSTAT_EN
    function automatic logic chstat_bit(input logic [7:0] idx);
        return (idx < 8'd32) ? CHSTAT_WORD[idx[4:0]] : 1'b0;
    endfunction

    logic cs_q, cs_d;

    // The bit is chosen at the left subframe and held for the right one.
    always_comb begin
        cs_d = cs_q;
        if (frame_ready && !chan_q) cs_d = chstat_bit(next_frame_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cs_q <= 1'b0;
        else        cs_q <= cs_d;
    end

    assign cs_bit = cs_q;
`else
    // Status word is only referenced here so the parameter list stays
    // identical in both builds; this net drives nothing.
    logic unused_chstat;
    assign unused_chstat = ^CHSTAT_WORD;
    assign cs_bit        = 1'b0;
`endif

    assign din          = din_q;
    assign vin          = vin_q;
    assign pre_sel      = pre_q;
    assign frame_idx    = frame_idx_q;
    assign underrun_cnt = und_q;

endmodule

// File: tb/tb_spdif_frame_scheduler.sv
module tb_spdif_frame_scheduler;

    localparam int          BF = 192;
    localparam logic [31:0] CW = 32'h0000_0005;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b1;
    logic        play        = 1'b0;
    logic        fifo_empty  = 1'b1;
    logic [7:0]  fifo_dout   = 8'h00;
    logic        frame_ready = 1'b0;
    logic        fifo_rd_en;
    logic [19:0] din;
    logic        vin;
    logic [1:0]  pre_sel;
    logic        cs_bit;
    logic [7:0]  frame_idx;
    logic [7:0]  underrun_cnt;

    spdif_frame_scheduler #(
        .BLOCK_FRAMES (BF),
        .CHSTAT_WORD  (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .play         (play),
        .fifo_empty   (fifo_empty),
        .fifo_dout    (fifo_dout),
        .fifo_rd_en   (fifo_rd_en),
        .frame_ready  (frame_ready),
        .din          (din),
        .vin          (vin),
        .pre_sel      (pre_sel),
        .cs_bit       (cs_bit),
        .frame_idx    (frame_idx),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    // External FIFO contents and the model's view of popped, unconsumed bytes
    logic [7:0] fq[$];
    logic [7:0] pend[$];
    int         pend_e[$];

    int   cyc   = 0;
    int   nchk  = 0;
    int   npass = 0;
    int   pops  = 0;
    logic prev_rd = 1'b0;

    // Expected outputs
    logic [19:0] e_din;
    logic        e_vin;
    logic [1:0]  e_pre;
    logic        e_cs;
    logic [7:0]  e_idx;
    int          e_und;
    int          nsub;

    task automatic report(input string name, input logic [63:0] act,
                          input logic [63:0] exp, input bit ok);
        nchk++;
        if (ok) npass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        report(name, {32'd0, act}, {32'd0, exp}, act === exp);
    endtask

    task automatic check_all(input string tag);
        logic [63:0] act, exp;
        act = {24'd0, din, vin, pre_sel, cs_bit, frame_idx, underrun_cnt};
        exp = {24'd0, e_din, e_vin, e_pre, e_cs, e_idx, e_und[7:0]};
        report(tag, act, exp, act === exp);
    endtask

    task automatic model_reset();
        pend.delete();
        pend_e.delete();
        e_din = 20'd0;
        e_vin = 1'b0;
        e_pre = 2'b00;
        e_cs  = 1'b0;
        e_idx = 8'd0;
        e_und = 0;
        nsub  = 0;
    endtask

    // Subframe request served at clock edge k. A popped byte is usable
    // two edges after its pop (one edge to capture, one to be staged).
    task automatic model_frame(input int k);
        int          fr;
        logic [23:0] s;
        if (pend.size() >= 3 && pend_e[2] <= k - 2) begin
            s = {pend[2], pend[1], pend[0]};
            repeat (3) begin
                void'(pend.pop_front());
                void'(pend_e.pop_front());
            end
            e_din = s[23:4];
            e_vin = 1'b1;
        end else begin
            e_din = 20'd0;
            e_vin = 1'b0;
            if (play && e_und < 255) e_und++;
        end
        fr    = (nsub / 2) % BF;
        e_idx = 8'(fr);
        if (nsub % 2 == 0) e_pre = (fr == 0) ? 2'b00 : 2'b01;
        else               e_pre = 2'b10;
        e_cs = 1'b0;
`ifdef SPDIF_CHSTAT_EN
        if (fr < 32) e_cs = CW[fr];
`endif
        nsub++;
    endtask

    // One clock cycle: inputs were set at the preceding negedge.
    task automatic step();
        logic       popped, rd, ok;
        logic [7:0] b;
        popped     = 1'b0;
        b          = 8'h00;
        fifo_empty = (fq.size() == 0);
        #1;
        rd = fifo_rd_en;
        if (rd === 1'b1) begin
            ok = !prev_rd && play && !fifo_empty && (pend.size() < 3);
            report("pop_legal", {60'd0, prev_rd, play, fifo_empty, pend.size() >= 3},
                   64'h4, ok);
            if (!fifo_empty) begin
                b = fq.pop_front();
                pend.push_back(b);
                pend_e.push_back(cyc + 1);
                popped = 1'b1;
                pops++;
            end
        end
        if (frame_ready) model_frame(cyc + 1);
        @(posedge clk);
        cyc++;
        #1;
        if (popped) fifo_dout = b;
        fifo_empty = (fq.size() == 0);
        prev_rd    = (rd === 1'b1);
        @(negedge clk);
        check_all("outputs");
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic pulse();
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
    endtask

    task automatic do_reset(input bit flush);
        frame_ready = 1'b0;
        play        = 1'b0;
        rst_n       = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        lit("reset_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        if (flush) fq.delete();
        fifo_empty = (fq.size() == 0);
        prev_rd    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_all("reset_hold");
    endtask

    initial begin
        int p0;
        logic fr_prev;
        model_reset();
        @(negedge clk);

        // Two preloaded samples, L then R
        do_reset(1'b1);
        fq.push_back(8'h56); fq.push_back(8'h34); fq.push_back(8'h12);
        fq.push_back(8'hAB); fq.push_back(8'h90); fq.push_back(8'h78);
        play = 1'b1;
        run(10);
        pulse();
        lit("t1_din_L", {12'd0, din}, 32'h12345);
        lit("t1_vin_L", {31'd0, vin}, 32'd1);
        lit("t1_pre_L", {30'd0, pre_sel}, 32'd0);
        run(10);
        pulse();
        lit("t1_din_R", {12'd0, din}, 32'h7890A);
        lit("t1_pre_R", {30'd0, pre_sel}, 32'd2);
        lit("t1_vin_R", {31'd0, vin}, 32'd1);

        // Empty FIFO: three underruns
        do_reset(1'b1);
        play = 1'b1;
        repeat (3) begin
            run(3);
            pulse();
        end
        lit("t2_underruns", {24'd0, underrun_cnt}, 32'd3);
        lit("t2_vin", {31'd0, vin}, 32'd0);
        lit("t2_din", {12'd0, din}, 32'd0);

        // Partial sample survives an underrun
        do_reset(1'b1);
        fq.push_back(8'h11);
        play = 1'b1;
        run(10);
        pulse();
        lit("t3_vin_under", {31'd0, vin}, 32'd0);
        lit("t3_und", {24'd0, underrun_cnt}, 32'd1);
        fq.push_back(8'h22); fq.push_back(8'h33);
        run(10);
        pulse();
        lit("t3_din", {12'd0, din}, 32'h33221);
        lit("t3_vin", {31'd0, vin}, 32'd1);
        lit("t3_pre", {30'd0, pre_sel}, 32'd2);

        // 192+ frames of continuous data
        do_reset(1'b1);
        play = 1'b1;
        for (int i = 0; i < 385; i++) begin
            if (fq.size() < 12)
                for (int j = 0; j < 6; j++) fq.push_back(8'($urandom_range(0, 255)));
            run(7);
            pulse();
            if (i == 0 || i == 384) lit("t4_pre_B", {30'd0, pre_sel}, 32'd0);
            if (i == 2)   lit("t4_pre_M", {30'd0, pre_sel}, 32'd1);
            if (i == 383) lit("t4_idx_last", {24'd0, frame_idx}, 32'd191);
            if (i == 384) lit("t4_idx_wrap", {24'd0, frame_idx}, 32'd0);
`ifdef SPDIF_CHSTAT_EN
            if (i == 4) lit("t4_cs_f2", {31'd0, cs_bit}, 32'd1);
`else
            if (i == 4) lit("t4_cs_f2", {31'd0, cs_bit}, 32'd0);
`endif
            if (i == 6) lit("t4_cs_f3", {31'd0, cs_bit}, 32'd0);
        end
        lit("t4_no_underrun", {24'd0, underrun_cnt}, 32'd0);

        // Underrun counter saturation
        do_reset(1'b1);
        play = 1'b1;
        repeat (300) begin
            pulse();
            run(1);
        end
        lit("t5_sat", {24'd0, underrun_cnt}, 32'd255);

        // Reset between byte 1 and byte 2 of a sample
        do_reset(1'b1);
        for (int j = 0; j < 9; j++) fq.push_back(8'($urandom_range(1, 255)));
        play = 1'b1;
        run(10);
        pulse();
        run(10);
        pulse();
        p0 = pops;
        for (int w = 0; w < 20 && pops < p0 + 2; w++) step();
        report("t6_wait_pops", 64'(pops - p0), 64'd2, pops >= p0 + 2);
        do_reset(1'b0);
        lit("t6_din", {12'd0, din}, 32'd0);
        lit("t6_vin", {31'd0, vin}, 32'd0);
        lit("t6_pre", {30'd0, pre_sel}, 32'd0);
        lit("t6_idx", {24'd0, frame_idx}, 32'd0);
        run(2);
        pulse();
        lit("t6_first_pre", {30'd0, pre_sel}, 32'd0);
        lit("t6_first_vin", {31'd0, vin}, 32'd0);
        lit("t6_first_und", {24'd0, underrun_cnt}, 32'd0);

        // Randomized traffic against the model
        do_reset(1'b1);
        play    = 1'b1;
        fr_prev = 1'b0;
        for (int c = 0; c < 15000; c++) begin
            if ($urandom_range(0, 199) == 0) play = ~play;
            if (fq.size() < 64 && $urandom_range(0, 99) < 35)
                fq.push_back(8'($urandom_range(0, 255)));
            frame_ready = !fr_prev && ($urandom_range(0, 7) == 0);
            fr_prev     = frame_ready;
            step();
            frame_ready = 1'b0;
            if ($urandom_range(0, 2999) == 0) begin
                do_reset(1'b0);
                play    = 1'b1;
                fr_prev = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
